cass_fsk_decoder: RTL and testbench

Demodulates the Sorcerer's Kansas City Standard cassette output (CASS_OUT FSK square wave) back into bytes. This is the receive end of the tape save path, so machine-saved data can be captured and uploaded to the host. It sits in the CLK12 domain beside the Sorcerer core and taps CASS_OUT and CASS_CTRL. Decoded bytes go into a small FIFO with a valid/ready output handshake.

---
 rtl/cass_fsk_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_cass_fsk_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cass_fsk_decoder.sv
// Kansas City Standard FSK demodulator for the Sorcerer CASS_OUT tap, with a FWFT byte FIFO.
// Optional macro CASS_DEC_STATS_EN adds saturating BYTE_CNT / ERR_CNT outputs.
module cass_fsk_decoder #(
    parameter int CLK_HZ         = 12000000,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_HALVES = 4
) (
    input  logic        CLK12,
    input  logic        RESET_N,
    input  logic        CASS_IN,
    input  logic        MOTOR,
    input  logic        BAUD1200,
    input  logic        SPEED2X,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        CARRIER,
    output logic        FRAME_ERR,
`ifdef CASS_DEC_STATS_EN
    output logic [15:0] BYTE_CNT,
    output logic [7:0]  ERR_CNT,
`endif
    output logic        OVERRUN
);

    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0]  THRESH  = 16'(CLK_HZ / 3200);
    // Timeout is a whole number of 1200 Hz half-periods (CLK_HZ/2400 cycles each).
    localparam logic [15:0]  LIMIT   = 16'(TIMEOUT_HALVES * CLK_HZ / 2400);
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    logic        sync1, sync2, sync2_q;
    logic        tone_edge;
    logic [15:0] hp_cnt;
    logic [15:0] thresh_cur, limit_cur;
    logic        timeout;
    logic        cls_valid, cls_short;
    logic        carrier_q;
    logic [4:0]  run_len, target;
    logic        run_short;
    logic        bit_stb, bit_val;
    logic        fsm_run;
    state_t      state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push, frame_err_d;
    logic        frame_err_q, overrun_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        valid, full, pop, wr_en;

    // NOTE: every clocked process uses non-blocking (<=) so all registers update together.
    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1   <= CASS_IN;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    assign tone_edge  = sync2 ^ sync2_q;
    assign thresh_cur = SPEED2X ? (THRESH >> 1) : THRESH;
    assign limit_cur  = SPEED2X ? (LIMIT >> 1) : LIMIT;
    assign timeout    = (hp_cnt >= limit_cur);

    // Half-period timer, classifier and carrier flag; an edge after a timeout only re-arms the timer.
    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            hp_cnt    <= '0;
            cls_valid <= 1'b0;
            cls_short <= 1'b0;
            carrier_q <= 1'b0;
        end else if (!MOTOR) begin
            hp_cnt    <= '0;
            cls_valid <= 1'b0;
            carrier_q <= 1'b0;
        end else begin
            cls_valid <= 1'b0;
            if (tone_edge) begin
                hp_cnt <= 16'd1;
                if (!timeout) begin
                    cls_valid <= 1'b1;
                    cls_short <= (hp_cnt < thresh_cur);
                    carrier_q <= 1'b1;
                end
            end else begin
                if (hp_cnt != '1) hp_cnt <= hp_cnt + 16'd1;
                if (timeout) carrier_q <= 1'b0;
            end
        end
    end

    assign target  = BAUD1200 ? (cls_short ? 5'd4 : 5'd2) : (cls_short ? 5'd16 : 5'd8);
    assign fsm_run = MOTOR & ~timeout;

    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            run_len   <= '0;
            run_short <= 1'b0;
            bit_stb   <= 1'b0;
            bit_val   <= 1'b0;
        end else if (!fsm_run) begin
            run_len <= '0;
            bit_stb <= 1'b0;
        end else begin
            bit_stb <= 1'b0;
            if (cls_valid) begin
                if (run_len != '0 && cls_short != run_short) begin
                    run_len   <= 5'd1;
                    run_short <= cls_short;
                end else if (run_len + 5'd1 == target) begin
                    bit_stb <= 1'b1;
                    bit_val <= cls_short;
                    run_len <= '0;
                end else begin
                    run_len   <= run_len + 5'd1;
                    run_short <= cls_short;
                end
            end
        end
    end

    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else if (!fsm_run) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    // NOTE: defaults first keep this block purely combinational (no latches).
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        if (bit_stb && fsm_run) begin
            unique case (state_q)
                IDLE: if (!bit_val) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
                DATA: begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
                STOP: begin
                    push        = bit_val;
                    frame_err_d = ~bit_val;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign valid = (count != '0);
    assign full  = (count == DEPTH_C);
    assign pop   = valid & OUT_READY;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= push & full & ~pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge CLK12) begin
        if (wr_en) mem[wr_ptr] <= shreg_q;
    end

    assign OUT_VALID = valid;
    assign OUT_DATA  = valid ? mem[rd_ptr] : 8'h00;
    assign CARRIER   = carrier_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;

`ifdef CASS_DEC_STATS_EN
    logic [15:0] byte_cnt;
    logic [7:0]  err_cnt;

    // Bytes reaching the push point count even when the FIFO drops them.
    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push && byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
            if ((frame_err_q || overrun_q) && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign BYTE_CNT = byte_cnt;
    assign ERR_CNT  = err_cnt;
`endif

endmodule

// File: tb/tb_cass_fsk_decoder.sv
// Directed bench for cass_fsk_decoder, scaled to CLK_HZ = 48000 (long half = 20, short half = 10 cycles).
// Compile with CASS_DEC_STATS_EN defined to also check the statistics counters.
module tb_cass_fsk_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cass = 1'b0;
    logic       motor = 1'b1;
    logic       baud1200 = 1'b0;
    logic       speed2x = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, carrier, frame_err, overrun;
`ifdef CASS_DEC_STATS_EN
    logic [15:0] byte_cnt;
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    cass_fsk_decoder #(.CLK_HZ(48000), .FIFO_DEPTH(16), .TIMEOUT_HALVES(4)) dut (
        .CLK12     (clk),
        .RESET_N   (rst_n),
        .CASS_IN   (cass),
        .MOTOR     (motor),
        .BAUD1200  (baud1200),
        .SPEED2X   (speed2x),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (ready),
        .CARRIER   (carrier),
        .FRAME_ERR (frame_err),
`ifdef CASS_DEC_STATS_EN
        .BYTE_CNT  (byte_cnt),
        .ERR_CNT   (err_cnt),
`endif
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One half-period: wait n cycles, then the toggle that ends it.
    task automatic half(input int n);
        repeat (n) @(negedge clk);
        cass = ~cass;
    endtask

    task automatic send_bit(input logic b);
        int len, halves;
        len    = b ? (speed2x ? 5 : 10) : (speed2x ? 10 : 20);
        halves = baud1200 ? (b ? 4 : 2) : (b ? 16 : 8);
        repeat (halves) half(len);
    endtask

    task automatic leader(input int nbits);
        repeat (nbits) send_bit(1'b1);
    endtask

    // Start bit, 8 data bits LSB first, first stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_carrier", 32'(carrier), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(100);

        // 300 baud leader + 0x55, latency to OUT_VALID
        leader(4);
        send_byte(8'h55, 1'b1);
        idle(4);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        idle(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_carrier", 32'(carrier), 32'd1);
        check("t1_fe_none", 32'(fe_cnt), 32'd0);
        pop_check("t1_data", 8'h55);
        check("t1_empty", 32'(out_valid), 32'd0);
        idle(120);
        check("t1_carrier_lost", 32'(carrier), 32'd0);

        // 1200 baud, doubled tones, back-to-back bytes
        baud1200 = 1'b1;
        speed2x  = 1'b1;
        leader(4);
        send_byte(8'hA3, 1'b1);
        send_bit(1'b1);
        send_byte(8'h00, 1'b1);
        send_bit(1'b1);
        idle(10);
        pop_check("t2_first", 8'hA3);
        pop_check("t2_second", 8'h00);
        check("t2_empty", 32'(out_valid), 32'd0);
        idle(120);

        // 300 baud framing error then a good byte
        baud1200 = 1'b0;
        speed2x  = 1'b0;
        leader(3);
        send_byte(8'h7E, 1'b0);
        send_bit(1'b1);
        idle(5);
        check("t3_fe_pulse", 32'(fe_cnt), 32'd1);
        check("t3_fifo_empty", 32'(out_valid), 32'd0);
        leader(2);
        send_byte(8'h12, 1'b1);
        send_bit(1'b1);
        idle(5);
        pop_check("t3_next", 8'h12);
        idle(120);

        // Overflow: 17 bytes with OUT_READY low
        baud1200 = 1'b1;
        leader(4);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
            send_bit(1'b1);
        end
        idle(10);
        check("t4_overrun", 32'(ov_cnt), 32'd1);
        check("t4_fe_none", 32'(fe_cnt), 32'd1);
`ifdef CASS_DEC_STATS_EN
        check("t4_byte_cnt", 32'(byte_cnt), 32'd21);
        check("t4_err_cnt", 32'(err_cnt), 32'd2);
`endif
        for (int i = 0; i < 16; i++) pop_check($sformatf("t4_drain%0d", i), 8'(i));
        check("t4_empty", 32'(out_valid), 32'd0);
        idle(120);

        // Carrier loss mid-byte discards the partial byte
        baud1200 = 1'b0;
        leader(3);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(70);
        check("t5_carrier_hold", 32'(carrier), 32'd1);
        idle(20);
        check("t5_carrier_drop", 32'(carrier), 32'd0);
        check("t5_partial_lost", 32'(out_valid), 32'd0);
        leader(3);
        send_byte(8'h3C, 1'b1);
        send_bit(1'b1);
        idle(5);
        pop_check("t5_after", 8'h3C);
        check("t5_empty", 32'(out_valid), 32'd0);
        idle(120);

        // MOTOR drop mid-byte keeps queued data
        leader(3);
        send_byte(8'h81, 1'b1);
        send_bit(1'b1);
        leader(1);
        send_bit(1'b0);
        send_bit(1'b1);
        motor = 1'b0;
        idle(30);
        check("t6_motor_carrier", 32'(carrier), 32'd0);
        check("t6_kept_valid", 32'(out_valid), 32'd1);
        check("t6_kept_data", 32'(out_data), 32'h81);
        motor = 1'b1;
        leader(3);
        send_byte(8'hC5, 1'b1);
        send_bit(1'b1);
        idle(5);
        pop_check("t6_old", 8'h81);
        pop_check("t6_new", 8'hC5);
        check("t6_empty", 32'(out_valid), 32'd0);
        idle(120);

        // Asynchronous reset with 5 bytes queued and the FSM in DATA
        baud1200 = 1'b1;
        leader(4);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
            send_bit(1'b1);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(5);
        check("t7_pre_valid", 32'(out_valid), 32'd1);
        check("t7_pre_carrier", 32'(carrier), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(out_valid), 32'd0);
        check("t7_rst_carrier", 32'(carrier), 32'd0);
        check("t7_rst_data", 32'(out_data), 32'd0);
`ifdef CASS_DEC_STATS_EN
        check("t7_rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("t7_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        idle(3);
        rst_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
